imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning number of 32-bit instruction-memory words.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, meaning a one-cycle request to begin a load session.
REQ-005 SHALL have port byte_valid, input, 1, meaning byte_data is offered.
REQ-006 SHALL have port byte_data, input, 8, meaning a program byte; stream order is MSB byte first.
REQ-007 SHALL have port byte_last, input, 1, meaning the offered byte is the final byte of the stream.
REQ-008 SHALL have port byte_ready, output, 1, meaning the loader accepts the byte this cycle.
REQ-009 SHALL have port wr_en, output, 1, meaning write strobe to the instruction memory write port.
REQ-010 SHALL have port wr_addr, output, 32, meaning the byte address of the word being written, always word-aligned.
REQ-011 SHALL have port wr_data, output, 32, meaning the assembled instruction word.
REQ-012 SHALL have port busy, output, 1, meaning a session is in progress.
REQ-013 SHALL have port done, output, 1, meaning the session has ended; held high until the next start or reset.
REQ-014 SHALL have port word_count, output, 8, meaning the number of words written this session.
REQ-015 SHALL have port err_partial, output, 1, meaning the stream ended mid-word.
REQ-016 SHALL have port err_overflow, output, 1, meaning more than DEPTH words were offered.

Function
REQ-017 SHALL implement a state machine with states IDLE, LOAD and DONE.
REQ-018 SHALL, on start in IDLE or DONE, enter LOAD next cycle and clear word_count, the byte index, done, err_partial and err_overflow.
REQ-019 SHALL ignore start while in LOAD.
REQ-020 SHALL drive byte_ready=1 only in LOAD; a byte is accepted on a cycle where byte_valid and byte_ready are both 1.
REQ-021 SHALL place the accepted byte at index k (0..3) into wr_data bits [31-8k:24-8k], so the first byte is bits [31:24].
REQ-022 SHALL, on accepting the byte at index 3, pulse wr_en for exactly the next cycle with wr_addr = word_count*4 and the full word on wr_data, then increment word_count.
REQ-023 SHALL hold wr_en=0 in every cycle other than those defined in REQ-022; wr_addr and wr_data may hold stale values while wr_en=0.
REQ-024 SHALL, when a byte at index 3 is accepted with byte_last=1, perform the write of REQ-022 and enter DONE on the same edge.
REQ-025 SHALL, when a byte at index 0..2 is accepted with byte_last=1, discard the partial word, issue no write, set err_partial and enter DONE.
REQ-026 SHALL, when a byte is accepted while word_count equals DEPTH, discard it, issue no write, set err_overflow and enter DONE.
REQ-027 SHALL drive busy=1 exactly in LOAD and done=1 exactly in DONE.
REQ-028 SHALL leave word_count, err_partial and err_overflow unchanged in DONE until the next start.
REQ-029 SHALL tolerate byte_valid gaps of any length in LOAD without changing state or the byte index.

Reset
REQ-030 SHALL, when reset=1 at a rising edge, enter IDLE, clear the byte index and set byte_ready, wr_en, busy, done, word_count, err_partial and err_overflow to 0.
REQ-031 SHALL let reset take priority over start and over a byte handshake on the same edge.
REQ-032 SHALL, on reset asserted mid-load, discard any partial word and issue no write on or after that edge.

Verification
REQ-033 SHALL verify this directed case: start; bytes 0x9D,0xE3,0xBF,0x98 with last on the 4th byte -> one wr_en pulse with wr_addr=0 and wr_data=0x9DE3BF98, then word_count=1, done=1 and both errors 0.
REQ-034 SHALL verify this directed case: 8 bytes with a 3-cycle valid gap after byte 2 -> writes at wr_addr 0x0 and 0x4 with the correct data, and no extra wr_en pulses.
REQ-035 SHALL verify this directed case: 6 bytes with last on the 6th byte -> one write at address 0, err_partial=1, word_count=1, done=1.
REQ-036 SHALL verify this directed case: with DEPTH=128, 129 words offered -> 128 writes with the last at wr_addr=0x1FC, err_overflow=1, word_count=128, and no write for word 129.
REQ-037 SHALL verify this directed case: reset after 2 bytes of a word -> no wr_en, all outputs 0, state IDLE; a subsequent start reloads from address 0.
REQ-038 SHALL verify this directed case: start asserted during LOAD -> ignored; start asserted in DONE -> counters and errors cleared and LOAD re-entered.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles an MSB-first byte stream into 32-bit
// words and writes them sequentially from address 0, flagging short or oversized streams.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | waiting for the first start after reset
//  LOAD  | accepting bytes, writing one word per four accepted bytes
//  DONE  | session ended; counters and error flags held until start
module imem_loader #(
    parameter int DEPTH = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [7:0]  word_count,
    output logic        err_partial,
    output logic        err_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // One bit wider than word_count so the full-memory condition is representable.
    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  idx;
    logic [23:0] hold;
    logic [8:0]  cnt;

    logic        accept;
    logic        clear;
    logic        wr_word;
    logic        end_partial;
    logic        end_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        byte_ready  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;
        clear       = 1'b0;
        wr_word     = 1'b0;
        end_partial = 1'b0;
        end_ovf     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    clear     = 1'b1;
                end
            end
            LOAD: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                accept     = byte_valid;
                if (byte_valid) begin
                    if (cnt == DEPTH_W) begin
                        end_ovf   = 1'b1;
                        state_nxt = DONE;
                    end else if (idx == 2'd3) begin
                        wr_word = 1'b1;
                        if (byte_last) begin
                            state_nxt = DONE;
                        end
                    end else if (byte_last) begin
                        end_partial = 1'b1;
                        state_nxt   = DONE;
                    end
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = LOAD;
                    clear     = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx          <= 2'd0;
            hold         <= 24'd0;
            cnt          <= 9'd0;
            wr_en        <= 1'b0;
            wr_addr      <= 32'd0;
            wr_data      <= 32'd0;
            err_partial  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            wr_en <= wr_word;
            if (clear) begin
                idx          <= 2'd0;
                cnt          <= 9'd0;
                err_partial  <= 1'b0;
                err_overflow <= 1'b0;
            end
            if (accept && !end_ovf && !end_partial) begin
                case (idx)
                    2'd0:    hold[23:16] <= byte_data;
                    2'd1:    hold[15:8]  <= byte_data;
                    2'd2:    hold[7:0]   <= byte_data;
                    default: ;
                endcase
                idx <= idx + 2'd1;
            end
            // The fourth byte goes straight onto the write bus rather than into hold.
            if (wr_word) begin
                wr_addr <= {21'd0, cnt, 2'b00};
                wr_data <= {hold, byte_data};
                cnt     <= cnt + 9'd1;
            end
            if (end_partial) begin
                err_partial <= 1'b1;
            end
            if (end_ovf) begin
                err_overflow <= 1'b1;
            end
        end
    end

    assign word_count = cnt[7:0];

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a cycle table for the basic sessions, then
// hand-written sequences for valid gaps, overflow and mid-load reset.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [7:0]  word_count;
    logic        err_partial;
    logic        err_overflow;

    int checks = 0;
    int errors = 0;

    logic [31:0] addr_q[$];
    logic [31:0] data_q[$];

    imem_loader #(.DEPTH(128)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_last    (byte_last),
        .byte_ready   (byte_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .word_count   (word_count),
        .err_partial  (err_partial),
        .err_overflow (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records every write strobe, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_en === 1'b1) begin
                addr_q.push_back(wr_addr);
                data_q.push_back(wr_data);
            end
        end
    end

    typedef struct {
        logic        st;
        logic        vl;
        logic [7:0]  d;
        logic        ls;
        logic        rdy;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        bsy;
        logic        dn;
        logic [7:0]  wc;
        logic        ep;
        logic        eo;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(input logic st, input logic vl, input logic [7:0] d,
                                input logic ls, input logic rdy, input logic we,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic bsy, input logic dn, input logic [7:0] wc,
                                input logic ep, input logic eo);
        vec_t v;
        v.st = st; v.vl = vl; v.d = d; v.ls = ls;
        v.rdy = rdy; v.we = we; v.addr = addr; v.data = data;
        v.bsy = bsy; v.dn = dn; v.wc = wc; v.ep = ep; v.eo = eo;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic ls);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = ls;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " byte_ready"}, {31'd0, byte_ready}, 32'd0);
        check({tag, " wr_en"}, {31'd0, wr_en}, 32'd0);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd0);
        check({tag, " word_count"}, {24'd0, word_count}, 32'd0);
        check({tag, " err_partial"}, {31'd0, err_partial}, 32'd0);
        check({tag, " err_overflow"}, {31'd0, err_overflow}, 32'd0);
    endtask

    initial begin
        int bad;
        logic [7:0] w8;
        logic [31:0] exp_word;

        //           st  vl  d      ls  rdy we  addr   data           bsy dn  wc     ep  eo
        vt[0]  = mk(0, 0, 8'h00, 0, 0, 0, 32'h0, 32'h0,        0, 0, 8'd0, 0, 0);
        vt[1]  = mk(1, 0, 8'h00, 0, 1, 0, 32'h0, 32'h0,        1, 0, 8'd0, 0, 0);
        vt[2]  = mk(0, 1, 8'h9D, 0, 1, 0, 32'h0, 32'h0,        1, 0, 8'd0, 0, 0);
        vt[3]  = mk(0, 1, 8'hE3, 0, 1, 0, 32'h0, 32'h0,        1, 0, 8'd0, 0, 0);
        vt[4]  = mk(0, 0, 8'h00, 0, 1, 0, 32'h0, 32'h0,        1, 0, 8'd0, 0, 0);
        vt[5]  = mk(0, 1, 8'hBF, 0, 1, 0, 32'h0, 32'h0,        1, 0, 8'd0, 0, 0);
        vt[6]  = mk(0, 1, 8'h98, 1, 0, 1, 32'h0, 32'h9DE3BF98, 0, 1, 8'd1, 0, 0);
        vt[7]  = mk(0, 0, 8'h00, 0, 0, 0, 32'h0, 32'h0,        0, 1, 8'd1, 0, 0);
        vt[8]  = mk(1, 1, 8'hFF, 0, 1, 0, 32'h0, 32'h0,        1, 0, 8'd0, 0, 0);
        vt[9]  = mk(1, 1, 8'h11, 0, 1, 0, 32'h0, 32'h0,        1, 0, 8'd0, 0, 0);
        vt[10] = mk(0, 1, 8'h22, 0, 1, 0, 32'h0, 32'h0,        1, 0, 8'd0, 0, 0);
        vt[11] = mk(0, 1, 8'h33, 0, 1, 0, 32'h0, 32'h0,        1, 0, 8'd0, 0, 0);
        vt[12] = mk(0, 1, 8'h44, 0, 1, 1, 32'h0, 32'h11223344, 1, 0, 8'd1, 0, 0);
        vt[13] = mk(0, 1, 8'h55, 0, 1, 0, 32'h0, 32'h0,        1, 0, 8'd1, 0, 0);
        vt[14] = mk(0, 1, 8'h66, 1, 0, 0, 32'h0, 32'h0,        0, 1, 8'd1, 1, 0);
        vt[15] = mk(1, 0, 8'h00, 0, 1, 0, 32'h0, 32'h0,        1, 0, 8'd0, 0, 0);
        vt[16] = mk(0, 1, 8'hAA, 1, 0, 0, 32'h0, 32'h0,        0, 1, 8'd0, 1, 0);

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Basic session, start in LOAD/DONE, partial word, immediate partial.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            start      = vt[i].st;
            byte_valid = vt[i].vl;
            byte_data  = vt[i].d;
            byte_last  = vt[i].ls;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d byte_ready", i), {31'd0, byte_ready}, {31'd0, vt[i].rdy});
            check($sformatf("vec%0d wr_en", i), {31'd0, wr_en}, {31'd0, vt[i].we});
            check($sformatf("vec%0d busy", i), {31'd0, busy}, {31'd0, vt[i].bsy});
            check($sformatf("vec%0d done", i), {31'd0, done}, {31'd0, vt[i].dn});
            check($sformatf("vec%0d word_count", i), {24'd0, word_count}, {24'd0, vt[i].wc});
            check($sformatf("vec%0d err_partial", i), {31'd0, err_partial}, {31'd0, vt[i].ep});
            check($sformatf("vec%0d err_overflow", i), {31'd0, err_overflow}, {31'd0, vt[i].eo});
            if (vt[i].we) begin
                check($sformatf("vec%0d wr_addr", i), wr_addr, vt[i].addr);
                check($sformatf("vec%0d wr_data", i), wr_data, vt[i].data);
            end
        end
        idle_inputs();

        // Eight bytes with a three-cycle valid gap after the second byte.
        repeat (2) @(negedge clk);
        addr_q.delete();
        data_q.delete();
        do_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        repeat (3) @(negedge clk);
        check("gap busy", {31'd0, busy}, 32'd1);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h06, 1'b0);
        send_byte(8'h07, 1'b0);
        send_byte(8'h08, 1'b1);
        repeat (3) @(negedge clk);
        check("gap write count", addr_q.size(), 32'd2);
        if (addr_q.size() == 2) begin
            check("gap addr0", addr_q[0], 32'h0);
            check("gap data0", data_q[0], 32'h01020304);
            check("gap addr1", addr_q[1], 32'h4);
            check("gap data1", data_q[1], 32'h05060708);
        end
        check("gap word_count", {24'd0, word_count}, 32'd2);
        check("gap done", {31'd0, done}, 32'd1);
        check("gap errors", {30'd0, err_partial, err_overflow}, 32'd0);

        // 129 words offered to a 128-word memory.
        addr_q.delete();
        data_q.delete();
        do_start();
        for (int w = 0; w < 128; w++) begin
            w8 = 8'(w);
            send_byte(w8, 1'b0);
            send_byte(8'hA5, 1'b0);
            send_byte(8'h5A, 1'b0);
            send_byte(~w8, 1'b0);
        end
        check("ovf ready before word 129", {31'd0, byte_ready}, 32'd1);
        send_byte(8'hEE, 1'b0);
        check("ovf done", {31'd0, done}, 32'd1);
        check("ovf byte_ready", {31'd0, byte_ready}, 32'd0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'hF1, 1'b1);
        repeat (3) @(negedge clk);
        check("ovf write count", addr_q.size(), 32'd128);
        bad = 0;
        for (int w = 0; w < addr_q.size(); w++) begin
            w8 = 8'(w);
            exp_word = {w8, 8'hA5, 8'h5A, ~w8};
            if (addr_q[w] !== 32'(w * 4) || data_q[w] !== exp_word) bad++;
        end
        check("ovf write sequence", bad, 32'd0);
        if (addr_q.size() > 0) begin
            check("ovf last addr", addr_q[addr_q.size() - 1], 32'h1FC);
            check("ovf last data", data_q[data_q.size() - 1], 32'h7FA55A80);
        end
        check("ovf err_overflow", {31'd0, err_overflow}, 32'd1);
        check("ovf err_partial", {31'd0, err_partial}, 32'd0);
        check("ovf word_count", {24'd0, word_count}, 32'd128);

        // Reset from DONE clears the held flags.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("rst_done");
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-word, coinciding with start and a byte offer.
        addr_q.delete();
        data_q.delete();
        do_start();
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b0);
        @(negedge clk);
        reset      = 1'b1;
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hC3;
        @(posedge clk);
        #1;
        check_all_zero("rst_mid");
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid no write", addr_q.size(), 32'd0);
        check("rst_mid idle", {30'd0, busy, done}, 32'd0);
        do_start();
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b1);
        repeat (2) @(negedge clk);
        check("reload write count", addr_q.size(), 32'd1);
        if (addr_q.size() == 1) begin
            check("reload addr", addr_q[0], 32'h0);
            check("reload data", data_q[0], 32'hDEADBEEF);
        end
        check("reload word_count", {24'd0, word_count}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
